// File: rtl/reg8_arb_pkg.sv
// Shared definitions for the 8-bit register write arbiter.
// State encoding and default sizing.
package reg8_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNTW  = 16;

endpackage

// File: rtl/reg8_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches last+1, last+2, ... modulo NREQ; first set bit wins.
module rr_pick
    import reg8_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic            valid,
    output logic [IDW-1:0]  win
);

    // Rotating priority scan starting just after the previous winner
    always_comb begin
        valid = 1'b0;
        win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last) + k) % NREQ;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/reg8_write_arbiter.sv
// Round-robin write arbiter for a shared load-enable register.
// Drives one write per winner, then checks the readback.
module reg8_write_arbiter
    import reg8_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNTW  = DEF_CNTW,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0]      reg_q,
    output logic                  load,
    output logic [WIDTH-1:0]      data_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  done,
    output logic                  err,
    output logic                  err_sticky,
    output logic [IDW-1:0]        last_id,
    output logic [CNTW-1:0]       wr_count
);

    state_t         state;
    state_t         nxt;
    logic           valid;
    logic [IDW-1:0] win;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .last  (last_id),
        .valid (valid),
        .win   (win)
    );

    // Outputs decoded from state and latched data only
    assign load = (state == LOAD);
    assign done = (state == CHECK);
    assign err  = done && (reg_q != data_in);

    // One-hot grant to the latched winner during LOAD
    always_comb begin
        gnt = '0;
        if (load) gnt[last_id] = 1'b1;
    end

    // Next-state selection; arbitration only matters in IDLE and CHECK
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = valid ? LOAD : IDLE;
            LOAD:    nxt = CHECK;
            CHECK:   nxt = valid ? LOAD : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= nxt;
    end

    // Latch winner and its data on entry to LOAD
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_in <= '0;
            last_id <= IDW'(NREQ - 1);
        end else if (nxt == LOAD) begin
            data_in <= req_data[int'(win)*WIDTH +: WIDTH];
            last_id <= win;
        end
    end

    // Completed-write counter and sticky readback error
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_count   <= '0;
            err_sticky <= 1'b0;
        end else if (done) begin
            wr_count <= wr_count + 1'b1;
            if (err) err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg8_write_arbiter.sv
// Bench for reg8_write_arbiter: directed table, corner sequences
// and random traffic against a cycle-level reference model.
module tb_reg8_write_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int CW   = 4;

    logic            CLK;
    logic            RST;
    logic [NREQ-1:0] req;
    logic [NREQ*W-1:0] req_data;
    logic [W-1:0]    reg_q;
    logic            load;
    logic [W-1:0]    data_in;
    logic [NREQ-1:0] gnt;
    logic            done;
    logic            err;
    logic            err_sticky;
    logic [1:0]      last_id;
    logic [CW-1:0]   wr_count;

    logic            corrupt;
    logic [W-1:0]    shreg;

    int checks;
    int fails;

    // model state
    bit        exp_load;
    bit        exp_done;
    bit        m_bad;
    bit        m_sticky;
    int        m_win;
    int        m_last;
    int        m_count;
    logic [7:0] m_data;

    reg8_write_arbiter #(.NREQ(NREQ), .WIDTH(W), .CNTW(CW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req        (req),
        .req_data   (req_data),
        .reg_q      (reg_q),
        .load       (load),
        .data_in    (data_in),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .err_sticky (err_sticky),
        .last_id    (last_id),
        .wr_count   (wr_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Shared register; corrupt stores the inverted value to force a readback error
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)       shreg <= '0;
        else if (load) shreg <= corrupt ? ~data_in : data_in;
    end
    assign reg_q = shreg;

    typedef struct {
        bit         rst;
        logic [3:0] rq;
        logic [31:0] dat;
        bit         bad;
        int         win;
        logic [7:0] dexp;
        bit         eexp;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, a, e, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return 0;
    endfunction

    task automatic compare_all();
        chk("load", 32'(load), 32'(exp_load));
        chk("gnt", 32'(gnt), exp_load ? (32'd1 << m_win) : 32'd0);
        chk("data_in", 32'(data_in), 32'(m_data));
        chk("done", 32'(done), 32'(exp_done));
        chk("err", 32'(err), 32'(exp_done && m_bad));
        chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
        chk("last_id", 32'(last_id), 32'(m_last));
        chk("wr_count", 32'(wr_count), 32'(m_count));
    endtask

    // A write occupies two cycles; a new one starts whenever the
    // previous cycle was not a load cycle and someone is requesting.
    task automatic step();
        bit wl;
        bit wd;
        @(posedge CLK);
        wl = exp_load;
        wd = exp_done;
        if (wd) begin
            m_count = (m_count + 1) % (1 << CW);
            if (m_bad) m_sticky = 1'b1;
        end
        if (wl) m_bad = corrupt;
        exp_done = wl;
        exp_load = 1'b0;
        if (!wl && req != 0) begin
            m_win    = pick(req, m_last);
            m_last   = m_win;
            m_data   = req_data[m_win*W +: W];
            exp_load = 1'b1;
        end
        @(negedge CLK);
        compare_all();
    endtask

    // Called at a falling edge; asserts reset mid-cycle
    task automatic do_reset();
        #2;
        RST      = 1'b1;
        exp_load = 1'b0;
        exp_done = 1'b0;
        m_bad    = 1'b0;
        m_sticky = 1'b0;
        m_last   = NREQ - 1;
        m_count  = 0;
        m_data   = '0;
        #1;
        compare_all();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic wait_load(input string nm);
        bit seen;
        seen = exp_load;
        for (int n = 0; n < 4 && !seen; n++) begin
            step();
            seen = exp_load;
        end
        if (!seen) begin
            checks++;
            fails++;
            $display("FAIL %s no load within 4 cycles", nm);
        end
    endtask

    initial begin
        checks   = 0;
        fails    = 0;
        RST      = 1'b1;
        req      = '0;
        req_data = '0;
        corrupt  = 1'b0;

        tbl[0]  = '{1, 4'b0001, 32'h000000A5, 0, 0, 8'hA5, 0};
        tbl[1]  = '{1, 4'b1111, 32'h44332211, 0, 0, 8'h11, 0};
        tbl[2]  = '{0, 4'b1111, 32'h44332211, 0, 1, 8'h22, 0};
        tbl[3]  = '{0, 4'b1111, 32'h44332211, 0, 2, 8'h33, 0};
        tbl[4]  = '{0, 4'b1111, 32'h44332211, 0, 3, 8'h44, 0};
        tbl[5]  = '{0, 4'b1111, 32'h44332211, 0, 0, 8'h11, 0};
        tbl[6]  = '{0, 4'b0010, 32'h0000BB00, 0, 1, 8'hBB, 0};
        tbl[7]  = '{0, 4'b1001, 32'h99000066, 0, 3, 8'h99, 0};
        tbl[8]  = '{0, 4'b1001, 32'h99000066, 0, 0, 8'h66, 0};
        tbl[9]  = '{0, 4'b0001, 32'h0000005A, 1, 0, 8'h5A, 1};
        tbl[10] = '{0, 4'b0100, 32'h00C30000, 0, 2, 8'hC3, 0};

        // directed table
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rst) do_reset();
            req      = tbl[i].rq;
            req_data = tbl[i].dat;
            corrupt  = tbl[i].bad;
            step();
            wait_load("tbl_wait");
            chk("tbl_gnt", 32'(gnt), 32'd1 << tbl[i].win);
            chk("tbl_data", 32'(data_in), 32'(tbl[i].dexp));
            step();
            chk("tbl_done", 32'(done), 32'd1);
            chk("tbl_err", 32'(err), 32'(tbl[i].eexp));
            if (i == 0) begin
                req = '0;
                step();
                chk("first_count", 32'(wr_count), 32'd1);
            end
        end
        req     = '0;
        corrupt = 1'b0;
        step();
        step();
        chk("sticky_hold", 32'(err_sticky), 32'd1);

        // reset during LOAD abandons the write
        req      = 4'b0100;
        req_data = 32'h00EE0000;
        step();
        wait_load("rst_wait");
        req = '0;
        do_reset();
        step();
        step();
        chk("rst_nodone", 32'(done), 32'd0);
        chk("rst_last", 32'(last_id), 32'd3);
        chk("rst_count", 32'(wr_count), 32'd0);

        // random traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (exp_load && m_win == i) begin
                        if ($urandom_range(1, 0) == 1) req[i] = 1'b0;
                        else req_data[i*W +: W] = 8'($urandom);
                    end
                end else if ($urandom_range(3, 0) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*W +: W] = 8'($urandom);
                end
            end
            corrupt = ($urandom_range(7, 0) == 0);
        end
        req     = '0;
        corrupt = 1'b0;
        step();
        step();

        // counter wrap with a single continuous requester
        do_reset();
        req      = 4'b0001;
        req_data = 32'h0000000F;
        for (int c = 0; c < 31; c++) step();
        chk("wrap_15", 32'(wr_count), 32'd15);
        step();
        step();
        chk("wrap_0", 32'(wr_count), 32'd0);
        req = '0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
